// File: rtl/imem_access_arbiter.sv
// Instruction-memory access arbiter: shares the single-port synchronous IM
// between the CPU fetch port and the program loader.  The loader owns the
// memory during BOOT; in RUN, fetch has priority but a pending loader request
// is forced through once it has been denied STARVE_LIMIT consecutive cycles.
// Optional build macro IMEM_ARB_STATS_EN adds grant/starvation statistics.
module imem_access_arbiter #(
    parameter int AW           = 9,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
`ifdef IMEM_ARB_STATS_EN
    output logic [31:0]   stat_fetch_cnt,
    output logic [31:0]   stat_ld_cnt,
    output logic [15:0]   stat_starve_cnt,
`endif
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [31:0]   fetch_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [31:0]   ld_rdata,
    input  logic          ld_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          boot_busy,
    output logic          cpu_stall
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic [31:0]   fetch_hold;
    logic [31:0]   ld_hold;
    logic          unused_bits;

    // Byte-offset and high address bits do not select an IM word.
    assign unused_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0],
                           ld_addr[31:AW+2], ld_addr[1:0]};

    assign starved   = (starve_cnt == LIMIT);
    assign boot_busy = (state == BOOT);
    assign cpu_stall = boot_busy | (fetch_req & ~fetch_gnt);

    // Read data is shown straight from the IM in the rvalid cycle and held afterwards.
    assign fetch_rdata = fetch_rvalid ? mem_rdata : fetch_hold;
    assign ld_rdata    = ld_rvalid    ? mem_rdata : ld_hold;

    // Grant selection, next phase, and IM port steering from the single winner.
    always_comb begin
        fetch_gnt  = 1'b0;
        ld_gnt     = 1'b0;
        next_state = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            BOOT: begin
                ld_gnt = ld_req;
                if (ld_done) next_state = RUN;
            end
            RUN: begin
                if (fetch_req && !(ld_req && starved)) fetch_gnt = 1'b1;
                else                                   ld_gnt    = ld_req;
            end
            default: next_state = BOOT;
        endcase
        if (fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[AW+1:2];
        end else if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr[AW+1:2];
            mem_wdata = ld_wdata;
        end
    end

    // Phase register, starvation counter and one-cycle read-return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            starve_cnt   <= '0;
            fetch_rvalid <= 1'b0;
            ld_rvalid    <= 1'b0;
            fetch_hold   <= '0;
            ld_hold      <= '0;
        end else begin
            state        <= next_state;
            fetch_rvalid <= fetch_gnt;
            ld_rvalid    <= ld_gnt & ~ld_we;
            if (state == RUN && ld_req && !ld_gnt) begin
                if (!starved) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            if (fetch_rvalid) fetch_hold <= mem_rdata;
            if (ld_rvalid)    ld_hold    <= mem_rdata;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    // Grant counters per requester plus cycles the loader was forced in over a fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetch_cnt  <= '0;
            stat_ld_cnt     <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (fetch_gnt) stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            if (ld_gnt)    stat_ld_cnt    <= stat_ld_cnt + 32'd1;
            if (ld_gnt && fetch_req && state == RUN)
                stat_starve_cnt <= stat_starve_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench for imem_access_arbiter: directed scenarios followed by
// randomized traffic checked against a cycle-level reference model.
module tb_imem_access_arbiter;

    localparam int AW = 9;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [31:0]   fetch_rdata;
    logic          ld_req;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          ld_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          boot_busy;
    logic          cpu_stall;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0]   stat_fetch_cnt;
    logic [31:0]   stat_ld_cnt;
    logic [15:0]   stat_starve_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic          init_mem = 1'b1;
    logic [31:0]   im      [0:511];
    logic [31:0]   ref_mem [0:511];

    imem_access_arbiter #(.AW(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
`ifdef IMEM_ARB_STATS_EN
        .stat_fetch_cnt(stat_fetch_cnt), .stat_ld_cnt(stat_ld_cnt),
        .stat_starve_cnt(stat_starve_cnt),
`endif
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_done(ld_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .boot_busy(boot_busy), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int i);
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Synchronous single-port instruction memory with a registered read port.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) im[i] <= mem_init(i);
        end else if (mem_en) begin
            if (mem_we) im[mem_addr] <= mem_wdata;
            else        mem_rdata    <= im[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_req = 0; fetch_addr = 0; ld_req = 0; ld_we = 0;
        ld_addr = 0; ld_wdata = 0; ld_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (boot_busy !== 1'b1) begin bad++; $display("FAIL reset_boot_busy got=%b want=1", boot_busy); end
        total++; if (fetch_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b want=00", fetch_rvalid, ld_rvalid); end
        total++; if (fetch_rdata !== 32'h0 || ld_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0", fetch_rdata, ld_rdata); end
        total++; if (cpu_stall !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL reset_stall_en got=%b%b want=10", cpu_stall, mem_en); end
        tick();
    endtask

    task automatic test_boot_load_and_fetch();
        do_reset();
        ld_req = 1; ld_we = 1; ld_addr = 32'h0; ld_wdata = 32'h0800_0313;
        @(negedge clk);
        total++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'd0) begin bad++; $display("FAIL boot_write0 gnt/we/addr got=%b/%b/%0d want=1/1/0", ld_gnt, mem_we, mem_addr); end
        tick(); ref_mem[0] = 32'h0800_0313;
        ld_addr = 32'h4; ld_wdata = 32'h0003_2383; ld_done = 1;
        @(negedge clk);
        total++; if (ld_gnt !== 1'b1 || boot_busy !== 1'b1 || mem_addr !== 9'd1) begin bad++; $display("FAIL boot_write1_done gnt/busy/addr got=%b/%b/%0d want=1/1/1", ld_gnt, boot_busy, mem_addr); end
        tick(); ref_mem[1] = 32'h0003_2383;
        clear_inputs();
        fetch_req = 1; fetch_addr = 32'h0;
        @(negedge clk);
        total++; if (boot_busy !== 1'b0) begin bad++; $display("FAIL run_after_done got=%b want=0", boot_busy); end
        total++; if (fetch_gnt !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL fetch0_gnt gnt/stall got=%b/%b want=1/0", fetch_gnt, cpu_stall); end
        tick();
        fetch_addr = 32'h4;
        @(negedge clk);
        total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h0800_0313) begin bad++; $display("FAIL fetch0_data got=%b/%h want=1/08000313", fetch_rvalid, fetch_rdata); end
        tick();
        fetch_req = 0;
        @(negedge clk);
        total++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h0003_2383) begin bad++; $display("FAIL fetch1_data got=%b/%h want=1/00032383", fetch_rvalid, fetch_rdata); end
        tick();
        @(negedge clk);
        total++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0003_2383) begin bad++; $display("FAIL fetch_pulse_hold got=%b/%h want=0/00032383", fetch_rvalid, fetch_rdata); end
        tick();
    endtask

    task automatic test_boot_blocks_fetch();
        do_reset();
        fetch_req = 1; fetch_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (fetch_gnt !== 1'b0 || cpu_stall !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL boot_fetch_block cyc=%0d gnt/stall/en got=%b/%b/%b want=0/1/0", i, fetch_gnt, cpu_stall, mem_en); end
            tick();
        end
        fetch_req = 0;
    endtask

    task automatic test_starvation();
        logic exp_l;
        do_reset();
        ld_done = 1; tick(); ld_done = 0;
        fetch_req = 1; fetch_addr = 32'h20; ld_req = 1; ld_we = 0; ld_addr = 32'h24;
        for (int i = 0; i < 27; i++) begin
            exp_l = ((i % 9) == 8);
            @(negedge clk);
            total++; if (ld_gnt !== exp_l || fetch_gnt !== !exp_l) begin bad++; $display("FAIL starve cyc=%0d ld/fetch got=%b/%b want=%b/%b", i, ld_gnt, fetch_gnt, exp_l, !exp_l); end
            tick();
        end
`ifdef IMEM_ARB_STATS_EN
        total++; if (stat_fetch_cnt !== 32'd24 || stat_ld_cnt !== 32'd3 || stat_starve_cnt !== 16'd3) begin bad++; $display("FAIL stats fetch/ld/starve got=%0d/%0d/%0d want=24/3/3", stat_fetch_cnt, stat_ld_cnt, stat_starve_cnt); end
`endif
    endtask

    task automatic test_ld_read();
        fetch_req = 0; ld_req = 1; ld_we = 0; ld_addr = 32'h14;
        @(negedge clk);
        total++; if (ld_gnt !== 1'b1 || mem_addr !== 9'd5 || mem_we !== 1'b0) begin bad++; $display("FAIL ld_read_gnt gnt/addr/we got=%b/%0d/%b want=1/5/0", ld_gnt, mem_addr, mem_we); end
        tick();
        ld_req = 0;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b1 || ld_rdata !== ref_mem[5]) begin bad++; $display("FAIL ld_read_data got=%b/%h want=1/%h", ld_rvalid, ld_rdata, ref_mem[5]); end
        tick();
    endtask

    task automatic test_reset_mid();
        fetch_req = 1; fetch_addr = 32'h8; rst = 1;
        tick();
        rst = 0; fetch_req = 0;
        @(negedge clk);
        total++; if (fetch_rvalid !== 1'b0 || boot_busy !== 1'b1 || cpu_stall !== 1'b1) begin bad++; $display("FAIL reset_mid rvalid/busy/stall got=%b/%b/%b want=0/1/1", fetch_rvalid, boot_busy, cpu_stall); end
        tick();
        @(negedge clk);
        total++; if (fetch_rvalid !== 1'b0) begin bad++; $display("FAIL reset_mid_later rvalid got=%b want=0", fetch_rvalid); end
        tick();
    endtask

    task automatic test_random();
        bit boot = 1;
        int denied = 0;
        bit ef, el, pf = 0, pl = 0, last_f = 1, last_l = 1;
        logic [31:0] pfd = 0, pld = 0;
        int fw = 0, lw = 0, mf = 0, ml = 0, ms = 0;
        logic [AW-1:0] eaddr;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (!fetch_req || last_f) begin
                fetch_req  = ($urandom % 4) != 0;
                fw         = $urandom % 16;
                fetch_addr = ($urandom & 32'hFFFF_F800) | (fw << 2) | ($urandom % 4);
            end
            if (!ld_req || last_l) begin
                ld_req   = ($urandom % 3) == 0;
                lw       = $urandom % 16;
                ld_we    = $urandom % 2;
                ld_wdata = $urandom;
                ld_addr  = ($urandom & 32'hFFFF_F800) | (lw << 2) | ($urandom % 4);
            end
            ld_done = ($urandom % 25) == 0;
            ef = 0; el = 0;
            if (boot)                                         el = ld_req;
            else if (fetch_req && !(ld_req && denied >= SL)) ef = 1;
            else                                              el = ld_req;
            eaddr = ef ? AW'(fw) : (el ? AW'(lw) : '0);
            @(negedge clk);
            total++; if (fetch_gnt !== ef || ld_gnt !== el) begin bad++; $display("FAIL rnd_gnt cyc=%0d fetch/ld got=%b/%b want=%b/%b", c, fetch_gnt, ld_gnt, ef, el); end
            total++; if (mem_en !== (ef | el) || mem_we !== (el & ld_we) || mem_addr !== eaddr) begin bad++; $display("FAIL rnd_mem cyc=%0d en/we/addr got=%b/%b/%0d want=%b/%b/%0d", c, mem_en, mem_we, mem_addr, ef | el, el & ld_we, eaddr); end
            total++; if (boot_busy !== boot || cpu_stall !== (boot | (fetch_req & !ef))) begin bad++; $display("FAIL rnd_stall cyc=%0d busy/stall got=%b/%b want=%b/%b", c, boot_busy, cpu_stall, boot, boot | (fetch_req & !ef)); end
            total++; if (fetch_rvalid !== pf || (pf && fetch_rdata !== pfd)) begin bad++; $display("FAIL rnd_fetch_ret cyc=%0d got=%b/%h want=%b/%h", c, fetch_rvalid, fetch_rdata, pf, pfd); end
            total++; if (ld_rvalid !== pl || (pl && ld_rdata !== pld)) begin bad++; $display("FAIL rnd_ld_ret cyc=%0d got=%b/%h want=%b/%h", c, ld_rvalid, ld_rdata, pl, pld); end
            tick();
            pf = ef; pfd = ref_mem[fw];
            pl = el && !ld_we; pld = ref_mem[lw];
            if (el && ld_we) ref_mem[lw] = ld_wdata;
            if (ef) mf++;
            if (el) ml++;
            if (el && fetch_req && !boot) ms++;
            if (!boot && ld_req && !el) denied = (denied < SL) ? denied + 1 : SL;
            else                        denied = 0;
            if (boot && ld_done) boot = 0;
            last_f = ef; last_l = el;
        end
`ifdef IMEM_ARB_STATS_EN
        total++; if (stat_fetch_cnt !== 32'(mf) || stat_ld_cnt !== 32'(ml) || stat_starve_cnt !== 16'(ms)) begin bad++; $display("FAIL rnd_stats got=%0d/%0d/%0d want=%0d/%0d/%0d", stat_fetch_cnt, stat_ld_cnt, stat_starve_cnt, mf, ml, ms); end
`endif
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = mem_init(i);
        clear_inputs();
        rst = 1;
        tick();
        init_mem = 0;
        test_reset();
        test_boot_load_and_fetch();
        test_boot_blocks_fetch();
        test_starvation();
        test_ld_read();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
